// File: rtl/pattern_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_rom_arbiter
//  Description : Round-robin arbiter giving NUM_REQ pattern sequencers shared
//                read access to one synchronous pattern ROM. One grant per
//                cycle, combinational grant and ROM address, registered
//                read-valid aligned with the ROM data.
//                Optional macro PATTERN_ROM_ARB_OUTREG_EN adds an output
//                register stage on o_rdata/o_rvalid (read latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDRW   = 4,
  parameter int DATAW   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*ADDRW-1:0] i_addr,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_rvalid,
  output logic [DATAW-1:0]         o_rdata,
  output logic [ADDRW-1:0]         o_rom_addr,
  input  logic [DATAW-1:0]         i_rom_data
);

  localparam int c_ptrw = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_ptrw-1:0]  r_ptr;
  logic [c_ptrw-1:0]  w_win_idx;
  logic [c_ptrw-1:0]  w_ptr_nxt;
  logic               w_found;
  logic               w_any;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ADDRW-1:0]   w_win_addr;
  logic [ADDRW-1:0]   r_addr_hold;
  logic [NUM_REQ-1:0] r_gnt_d;
  logic [ADDRW-1:0]   w_addr_arr [NUM_REQ];

  // Unpack the per-requester address slices for indexed selection.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = i_addr[g*ADDRW +: ADDRW];
  end

  // Round-robin search: start at the pointer, ascend modulo NUM_REQ.
  always_comb begin : comb_pick
    int s;
    s         = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(r_ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!w_found && i_req[s[c_ptrw-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = s[c_ptrw-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign w_any      = w_found & i_rst_n;
  assign w_gnt      = w_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx) : '0;
  assign w_win_addr = w_addr_arr[w_win_idx];
  assign w_ptr_nxt  = (w_win_idx == c_ptrw'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  assign o_gnt      = w_gnt;
  assign o_rom_addr = w_any ? w_win_addr : r_addr_hold;

  // Priority pointer advances past the winner; holds when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Remember the last granted address so the ROM address is stable when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_hold <= '0;
    end else if (w_any) begin
      r_addr_hold <= w_win_addr;
    end
  end

  // Grant shadow: marks which requester owns the ROM data next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt_d <= '0;
    end else begin
      r_gnt_d <= w_gnt;
    end
  end

`ifdef PATTERN_ROM_ARB_OUTREG_EN
  logic [NUM_REQ-1:0] r_rvalid_q;
  logic [DATAW-1:0]   r_rdata_q;

  // Extra output stage: retimes data and valid together by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid_q <= '0;
      r_rdata_q  <= '0;
    end else begin
      r_rvalid_q <= r_gnt_d;
      r_rdata_q  <= i_rom_data;
    end
  end

  assign o_rvalid = r_rvalid_q;
  assign o_rdata  = r_rdata_q;
`else
  assign o_rvalid = r_gnt_d;
  assign o_rdata  = i_rom_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_rom_arbiter
//  Description : Self-checking bench for pattern_rom_arbiter: directed
//                scenarios plus randomized requesters against a
//                round-robin reference model and a ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef PATTERN_ROM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q = '0;
  logic [DW-1:0]   rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_ptr  = 0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  pv [2];
  logic [DW-1:0] pd [2];

  pattern_rom_arbiter #(.NUM_REQ(N), .ADDRW(AW), .DATAW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_addr     (addr),
    .o_gnt      (gnt),
    .o_rvalid   (rvalid),
    .o_rdata    (rdata),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_q)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // First set request scanning up from p, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [N*AW-1:0] v;
    v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    return v;
  endfunction

  // One clock cycle: drive inputs at negedge, check, then advance the model.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*AW-1:0] a, output int k);
    logic [N-1:0] one;
    logic [N-1:0] exp_g;
    one = 1;
    @(negedge clk);
    rst_n = rst;
    req   = r;
    addr  = a;
    #1;
    if (!rst) begin
      m_ptr  = 0;
      m_addr = '0;
      pv[0]  = '0;
      pv[1]  = '0;
      k      = -1;
    end else begin
      k = rr_pick(r, m_ptr);
    end
    exp_g = (k >= 0) ? (one << k) : '0;
    if (k >= 0) m_addr = a[k*AW +: AW];
    check_eq("gnt", 32'(gnt), 32'(exp_g));
    check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    check_eq("rvalid", 32'(rvalid), 32'(pv[LAT-1]));
    if (pv[LAT-1] != '0) check_eq("rdata", 32'(rdata), 32'(pd[LAT-1]));
    @(posedge clk);
    if (k >= 0) m_ptr = (k + 1) % N;
    pv[1] = pv[0];
    pd[1] = pd[0];
    pv[0] = exp_g;
    pd[0] = rom[m_addr];
  endtask

  initial begin
    int k;
    logic [N-1:0]    pend;
    logic [AW-1:0]   pa [N];
    logic [N*AW-1:0] a;

    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    rom[5] = 16'hA5A5;
    pv[0] = '0; pv[1] = '0; pd[0] = '0; pd[1] = '0;

    // Reset: no grants regardless of requests, outputs cleared
    step(1'b0, '0, '0, k);
    step(1'b0, 4'b1111, pk(1, 2, 3, 4), k);

    // Single read from address 5
    step(1'b1, 4'b0001, pk(5, 0, 0, 0), k);
    repeat (3) step(1'b1, '0, '0, k);

    // All requesting: rotate every cycle
    repeat (8) step(1'b1, 4'b1111, pk(1, 2, 3, 4), k);
    repeat (3) step(1'b1, '0, '0, k);

    // Pointer wrap: grant 1, then 0011 -> 0 then 1
    step(1'b1, 4'b0010, pk(0, 7, 0, 0), k);
    step(1'b1, 4'b0011, pk(6, 7, 0, 0), k);
    step(1'b1, 4'b0010, pk(0, 8, 0, 0), k);

    // Withdrawn request: index 0 wins, index 2 drops out
    step(1'b1, 4'b1000, pk(0, 0, 0, 9), k);
    step(1'b1, 4'b0101, pk(9, 0, 2, 0), k);
    step(1'b1, 4'b0000, '0, k);
    repeat (2) step(1'b1, '0, '0, k);

    // Requester 0 continuous, requester 1 once
    step(1'b1, 4'b0001, pk(3, 0, 0, 0), k);
    step(1'b1, 4'b0011, pk(4, 10, 0, 0), k);
    step(1'b1, (k == 1) ? 4'b0001 : 4'b0011, pk(5, 10, 0, 0), k);
    step(1'b1, 4'b0001, pk(6, 0, 0, 0), k);
    repeat (3) step(1'b1, '0, '0, k);

    // Randomized requesters obeying the hold-until-grant protocol
    pend = '0;
    for (int r = 0; r < N; r++) pa[r] = '0;
    repeat (400) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 9) < 4) begin
            pend[r] = 1'b1;
            pa[r]   = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[r] = 1'b0;
        end
      end
      for (int r = 0; r < N; r++) a[r*AW +: AW] = pa[r];
      step(1'b1, pend, a, k);
      if (k >= 0) begin
        if ($urandom_range(0, 9) >= 3) pend[k] = 1'b0;
        else pa[k] = 4'($urandom_range(0, 15));
      end
    end
    repeat (3) step(1'b1, '0, '0, k);

    // Grant to 3, reset next cycle drops the read; then 1001 -> 0001
    step(1'b1, 4'b1000, pk(0, 0, 0, 11), k);
    step(1'b0, 4'b1111, pk(1, 2, 3, 4), k);
    step(1'b0, '0, '0, k);
    step(1'b1, 4'b1001, pk(12, 0, 0, 13), k);
    repeat (3) step(1'b1, '0, '0, k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_rom_arbiter.md
PATTERN_ROM_ARBITER -- requirements
Module: pattern_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting pattern sequencers (2..8).
REQ-002 Parameter ADDRW, default 4: ROM address width.
REQ-003 Parameter DATAW, default 16: ROM word width.
REQ-004 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  NUM_REQ  per-requester read request, level.
REQ-007 i_addr  input  NUM_REQ*ADDRW  packed request addresses; requester k at bits [k*ADDRW +: ADDRW].
REQ-008 o_gnt  output  NUM_REQ  one-hot grant pulse: request accepted this cycle.
REQ-009 o_rvalid  output  NUM_REQ  one-hot pulse: o_rdata belongs to that requester.
REQ-010 o_rdata  output  DATAW  read data, broadcast to all requesters.
REQ-011 o_rom_addr  output  ADDRW  address to the shared synchronous pattern ROM.
REQ-012 i_rom_data  input  DATAW  ROM data, valid one cycle after o_rom_addr is presented.

Function
REQ-013 Each cycle with any i_req bit set, the block SHALL grant exactly one requester, chosen combinationally by round-robin from a priority pointer.
REQ-014 Search order SHALL start at the pointer index and ascend modulo NUM_REQ; the first set i_req bit wins.
REQ-015 On a grant to index k, the pointer SHALL become (k+1) mod NUM_REQ at the next edge; with no requests the pointer SHALL hold.
REQ-016 o_gnt SHALL be combinational, same cycle as the winning i_req; o_rom_addr SHALL equal the winner's i_addr slice that cycle, else hold its last value.
REQ-017 A requester SHALL hold i_req and i_addr stable until it sees its o_gnt; it deasserts i_req in the grant cycle unless it wants another read.
REQ-018 If a request is withdrawn before its grant, the block SHALL NOT grant it and SHALL NOT produce an o_rvalid for it.
REQ-019 A registered shadow of o_gnt SHALL drive o_rvalid one cycle after the grant, aligned with i_rom_data passed through to o_rdata (read latency 1).
REQ-020 Back-to-back grants SHALL be accepted every cycle (throughput 1 read/cycle); with continuous requests a waiting requester SHALL be granted within NUM_REQ-1 cycles.
REQ-021 A requester holding i_req continuously after its grant SHALL receive another grant only after all other requesters that were pending have been served once.
REQ-022 o_rdata SHALL be undefined-but-stable and ignored when o_rvalid is zero.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately clear the pointer to 0, o_rvalid to 0, o_rom_addr to 0 and all pipeline state.
REQ-024 A read granted in the cycle before or during reset SHALL be dropped: no o_rvalid after reset release.
REQ-025 While i_rst_n is low o_gnt SHALL be 0 regardless of i_req.
REQ-026 The first grant after reset release SHALL follow priority order from index 0.

Configuration
REQ-027 Macro PATTERN_ROM_ARB_OUTREG_EN: when defined, o_rdata and o_rvalid SHALL be registered once more (read latency 2, o_rvalid two cycles after o_gnt), throughput unchanged; reset clears the extra stage.
REQ-028 When PATTERN_ROM_ARB_OUTREG_EN is undefined, latency SHALL be 1 as in REQ-019, with no extra registers.

Verification
REQ-029 Reset, then i_req=0001, addr0=5, ROM[5]=16'hA5A5 -> o_gnt=0001 same cycle; next cycle o_rvalid=0001, o_rdata=16'hA5A5 (two cycles later with OUTREG_EN).
REQ-030 i_req=1111 held 8 cycles, addresses 1,2,3,4 -> grants in order 0001,0010,0100,1000,0001,... every cycle; rvalid sequence identical, shifted by latency.
REQ-031 Pointer at 2 after granting index 1, then i_req=0011 -> grant 0001 (wraps), then 0010.
REQ-032 i_req=0100 raised then dropped in a cycle where index 0 wins -> no grant and no rvalid for index 2.
REQ-033 Grant to index 3 in cycle N, i_rst_n low in cycle N+1 -> o_rvalid stays 0; after release, i_req=1001 -> grant 0001.
REQ-034 Requester 0 holds i_req continuously while requester 1 requests once -> requester 1 granted within 1 cycle; requester 0 never granted twice consecutively while requester 1 pends.
